multicycle_control_unit: RTL

// - Sequenced successor of the LITE-16 combinational decoder.
// - Registers the opcode class flags (ri/cmp/mem/ld/st/jmp/fn) and drives a

---
 rtl/multicycle_control_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Five-phase (FETCH/DECODE/EXEC/MEM/WB) sequencer for the LITE-16 datapath.
// Class flags are latched once per instruction in DECODE; control strobes are
// decoded from the state register, the latched flags, and the two status
// inputs (mem_ack, cond) that complete the memory and branch phases.
// Optional macro CU_MEM_TIMEOUT_EN adds a memory-wait watchdog that raises
// a one-cycle fault pulse and abandons the instruction.
module multicycle_control_unit #(
    parameter int OPCODE_W    = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] codeop,
    input  logic                cond,
    input  logic                mem_ack,
    output logic                ri,
    output logic                cmp,
    output logic                mem,
    output logic                ld,
    output logic                st,
    output logic                jmp,
    output logic                fn,
    output logic                ir_we,
    output logic                pc_we,
    output logic                pc_sel,
    output logic                alu_en,
    output logic                reg_we,
    output logic                mem_req,
    output logic                mem_we,
    output logic                busy,
    output logic                fault
);

    // Elaboration-time parameter sanity checks
    if (OPCODE_W < 4) begin : g_bad_opcode_w
        $error("OPCODE_W must be >= 4");
    end
    if (MEM_TIMEOUT < 2) begin : g_bad_mem_timeout
        $error("MEM_TIMEOUT must be >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    state_t state_reg, state_next;

    logic [2:0] op_top3;
    logic [1:0] op_top2;
    logic [1:0] op_low2;
    logic       timed_out;

    assign op_top3 = codeop[OPCODE_W-1 -: 3];
    assign op_top2 = codeop[OPCODE_W-1 -: 2];
    assign op_low2 = codeop[1:0];

`ifdef CU_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_reg;

    assign timed_out = (wait_cnt_reg == CNT_W'(MEM_TIMEOUT));

    // Count consecutive un-acked request cycles; any other cycle clears it,
    // so the count restarts on every entry to FETCH or MEM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
        end else if ((state_reg == S_FETCH || state_reg == S_MEM) && !mem_ack && !timed_out) begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
        end else begin
            wait_cnt_reg <= '0;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Latch the opcode class flags once per instruction, in DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ri  <= 1'b0;
            cmp <= 1'b0;
            mem <= 1'b0;
            ld  <= 1'b0;
            st  <= 1'b0;
            jmp <= 1'b0;
            fn  <= 1'b0;
        end else if (state_reg == S_DECODE) begin
            ri  <= (op_top3 == 3'b111);
            cmp <= (op_low2 == 2'b11);
            mem <= (op_top3 == 3'b110);
            ld  <= (op_top3 == 3'b110) && !codeop[0];
            st  <= (op_top3 == 3'b110) &&  codeop[0];
            jmp <= (op_top2 == 2'b10);
            fn  <= (op_top2 == 2'b10) && (op_low2 == 2'b11);
        end
    end

    // Next-state and control-strobe decode
    always_comb begin
        state_t boundary;
        state_next = state_reg;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 1'b0;
        alu_en     = 1'b0;
        reg_we     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        fault      = 1'b0;
        busy       = (state_reg != S_IDLE);
        // run only matters where an instruction ends
        boundary   = run ? S_FETCH : S_IDLE;

        case (state_reg)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (timed_out) begin
                    fault      = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        ir_we      = 1'b1;
                        pc_we      = 1'b1;
                        state_next = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                state_next = S_EXEC;
            end
            S_EXEC: begin
                alu_en = 1'b1;
                if (jmp) begin
                    if (!fn || cond) begin
                        pc_we  = 1'b1;
                        pc_sel = 1'b1;
                    end
                    state_next = boundary;
                end else if (mem) begin
                    state_next = S_MEM;
                end else if (cmp) begin
                    state_next = boundary;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                if (timed_out) begin
                    fault      = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    mem_req = 1'b1;
                    mem_we  = st;
                    if (mem_ack) state_next = ld ? S_WB : boundary;
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                state_next = boundary;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
